// File: rtl/axis_out_packer.sv
// axis_out_packer: splits S_WORDS-wide AXI-Stream beats into M_WORDS chunks, dropping empty tail chunks; chunk 0 one cycle after accept.
// Backpressure: s ready only when empty or while the final chunk hands off (bypass refill); `AXIS_OUT_PACKER_STATS_EN adds frame/stall counters.
module axis_out_packer #(
  parameter int WORD_WIDTH = 32,
  parameter int S_WORDS    = 8,
  parameter int M_WORDS    = 2
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [S_WORDS*WORD_WIDTH-1:0] s_axis_tdata,
  input  logic [S_WORDS-1:0]            s_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [M_WORDS*WORD_WIDTH-1:0] m_axis_tdata,
  output logic [M_WORDS-1:0]            m_axis_tkeep
`ifdef AXIS_OUT_PACKER_STATS_EN
  ,
  output logic [31:0]                   frame_count,
  output logic [31:0]                   stall_count
`endif
);

  localparam int RATIO = S_WORDS / M_WORDS;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CW    = M_WORDS * WORD_WIDTH;

  typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_t;

  typedef struct packed {
    logic [S_WORDS*WORD_WIDTH-1:0] dat;
    logic [S_WORDS-1:0]            keep;
    logic                          last;
  } hold_t;

  state_t             state_q;
  state_t             state_d;
  hold_t              hold_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   fin_q;
  logic [IDX_W-1:0]   in_fin;
  logic               in_any;
  logic               at_fin;
  logic               m_hs;
  logic               s_hs;
  logic               load;

  // Highest chunk holding any kept word; empty lower chunks still go out.
  always_comb begin
    in_fin = '0;
    for (int c = 0; c < RATIO; c++) begin
      if (|s_axis_tkeep[c*M_WORDS +: M_WORDS]) begin
        in_fin = IDX_W'(c);
      end
    end
  end

  assign in_any        = |s_axis_tkeep;
  assign m_axis_tvalid = (state_q == SEND);
  assign at_fin        = (idx_q == fin_q);
  assign m_hs          = m_axis_tvalid && m_axis_tready;
  assign s_axis_tready = !areset && (!m_axis_tvalid || (m_hs && at_fin));
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  // A fully empty non-last beat is swallowed without occupying the register.
  assign load          = s_hs && (in_any || s_axis_tlast);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (load) state_d = SEND;
      end
      SEND: begin
        if (m_hs && at_fin) state_d = load ? SEND : EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    for (int c = 0; c < RATIO; c++) begin
      if (idx_q == IDX_W'(c)) begin
        m_axis_tdata = hold_q.dat[c*CW +: CW];
        m_axis_tkeep = hold_q.keep[c*M_WORDS +: M_WORDS];
      end
    end
  end

  assign m_axis_tlast = m_axis_tvalid && hold_q.last && at_fin;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      fin_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (s_hs) begin
        idx_q <= '0;
      end else if (m_hs && !at_fin) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (load) begin
        hold_q <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
        fin_q  <= in_fin;
      end
    end
  end

`ifdef AXIS_OUT_PACKER_STATS_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      frame_count <= '0;
      stall_count <= '0;
    end else begin
      if (m_hs && m_axis_tlast) frame_count <= frame_count + 32'd1;
      if (m_axis_tvalid && !m_axis_tready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_out_packer.sv
// Bench for axis_out_packer: queue-based chunking model, directed cases plus a randomized valid/ready frame.
module tb_axis_out_packer;

  localparam int W   = 32;
  localparam int SW  = 8;
  localparam int MW  = 2;
  localparam int SDW = SW * W;
  localparam int MDW = MW * W;

  typedef struct packed {
    logic [SDW-1:0] dat;
    logic [SW-1:0]  keep;
    logic           last;
  } in_beat_t;

  typedef struct packed {
    logic [MDW-1:0] dat;
    logic [MW-1:0]  keep;
    logic           last;
  } out_beat_t;

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic           s_axis_tlast = 1'b0;
  logic [SDW-1:0] s_axis_tdata = '0;
  logic [SW-1:0]  s_axis_tkeep = '0;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b0;
  logic           m_axis_tlast;
  logic [MDW-1:0] m_axis_tdata;
  logic [MW-1:0]  m_axis_tkeep;
`ifdef AXIS_OUT_PACKER_STATS_EN
  logic [31:0]    frame_count;
  logic [31:0]    stall_count;
`endif

  axis_out_packer #(.WORD_WIDTH(W), .S_WORDS(SW), .M_WORDS(MW)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep)
`ifdef AXIS_OUT_PACKER_STATS_EN
    ,
    .frame_count   (frame_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  in_beat_t  src_q[$];
  out_beat_t exp_q[$];
  int        out_cyc[$];
  int        acc_cyc[$];
  logic      out_srdy[$];

  int   cyc = 0;
  int   out_cnt = 0;
  int   s_prob = 100;
  int   m_prob = 100;
  int   frame_ref = 0;
  int   stall_ref = 0;
  logic s_hs_pend = 1'b0;
  logic prev_stall = 1'b0;
  logic [MDW-1:0] prev_dat = '0;
  logic [MW-1:0]  prev_keep = '0;
  logic           prev_last = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a beat becomes ceil((highest kept word + 1) / MW) chunks, tlast on the final one.
  function automatic void model_push(input in_beat_t b);
    int hi = -1;
    int n;
    out_beat_t o;
    for (int w = 0; w < SW; w++) if (b.keep[w]) hi = w;
    if (hi < 0) begin
      if (b.last) begin
        o.dat = '0;
        o.keep = '0;
        o.last = 1'b1;
        exp_q.push_back(o);
      end
      return;
    end
    n = hi / MW + 1;
    for (int c = 0; c < n; c++) begin
      o.dat  = b.dat[c*MDW +: MDW];
      o.keep = b.keep[c*MW +: MW];
      o.last = b.last && (c == n - 1);
      exp_q.push_back(o);
    end
  endfunction

  function automatic logic [MDW-1:0] word_mask(input logic [MW-1:0] k);
    logic [MDW-1:0] m = '0;
    for (int w = 0; w < MW; w++) m[w*W +: W] = {W{k[w]}};
    return m;
  endfunction

  function automatic in_beat_t mk_beat(input int base, input logic [SW-1:0] keep, input logic last);
    in_beat_t b;
    for (int w = 0; w < SW; w++) b.dat[w*W +: W] = W'(base + w);
    b.keep = keep;
    b.last = last;
    return b;
  endfunction

  task automatic step();
    out_beat_t e;
    in_beat_t  nb;
    @(negedge aclk);
    if (s_hs_pend) s_axis_tvalid = 1'b0;
    if (!s_axis_tvalid && src_q.size() > 0 && $urandom_range(99) < s_prob) begin
      nb = src_q.pop_front();
      s_axis_tdata  = nb.dat;
      s_axis_tkeep  = nb.keep;
      s_axis_tlast  = nb.last;
      s_axis_tvalid = 1'b1;
    end
    m_axis_tready = ($urandom_range(99) < m_prob);
    #1;
    if (prev_stall) begin
      chk("hold_vld", m_axis_tvalid, 1);
      chk("hold_dat", m_axis_tdata, prev_dat);
      chk("hold_keep", m_axis_tkeep, prev_keep);
      chk("hold_last", m_axis_tlast, prev_last);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      out_cyc.push_back(cyc);
      out_srdy.push_back(s_axis_tready);
      out_cnt++;
      if (m_axis_tlast) frame_ref++;
      if (exp_q.size() == 0) begin
        chk("extra_beat", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("out_keep", m_axis_tkeep, e.keep);
        chk("out_last", m_axis_tlast, e.last);
        chk("out_dat", m_axis_tdata & word_mask(e.keep), e.dat & word_mask(e.keep));
      end
    end
    if (m_axis_tvalid && !m_axis_tready) stall_ref++;
    s_hs_pend = s_axis_tvalid && s_axis_tready;
    if (s_hs_pend) begin
      model_push({s_axis_tdata, s_axis_tkeep, s_axis_tlast});
      acc_cyc.push_back(cyc);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_dat   = m_axis_tdata;
    prev_keep  = m_axis_tkeep;
    prev_last  = m_axis_tlast;
    cyc++;
  endtask

  task automatic run_until_idle(input string tag);
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < 20000) begin
      step();
      n++;
      if (src_q.size() == 0 && !s_axis_tvalid && !m_axis_tvalid) quiet++;
      else quiet = 0;
    end
    chk({tag, "_done"}, quiet >= 4, 1);
    chk({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic clr();
    out_cyc.delete();
    acc_cyc.delete();
    out_srdy.delete();
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    s_hs_pend = 1'b0;
    prev_stall = 1'b0;
    #1;
    chk("rst_s_rdy", s_axis_tready, 0);
    @(negedge aclk);
    #1;
    chk("rst_m_vld", m_axis_tvalid, 0);
    chk("rst_m_last", m_axis_tlast, 0);
    chk("rst_s_rdy2", s_axis_tready, 0);
`ifdef AXIS_OUT_PACKER_STATS_EN
    chk("rst_frames", frame_count, 0);
    chk("rst_stalls", stall_count, 0);
`endif
    areset = 1'b0;
    exp_q.delete();
    src_q.delete();
    frame_ref = 0;
    stall_ref = 0;
    #1;
    chk("rel_s_rdy", s_axis_tready, 1);
  endtask

  initial begin
    int base;
    int n;
    in_beat_t b;

    do_reset();

    // Full beat, words 1..8
    clr();
    src_q.push_back(mk_beat(1, 8'hFF, 1'b0));
    run_until_idle("t1");
    chk("t1_cnt", out_cyc.size(), 4);
    if (out_cyc.size() >= 4 && acc_cyc.size() >= 1) begin
      chk("t1_lat", out_cyc[0] - acc_cyc[0], 1);
      chk("t1_span", out_cyc[3] - out_cyc[0], 3);
      chk("t1_srdy", {out_srdy[3], out_srdy[2], out_srdy[1], out_srdy[0]}, 4'b1000);
    end

    // Partial last beat, words 9..11
    clr();
    src_q.push_back(mk_beat(9, 8'h07, 1'b1));
    run_until_idle("t2");
    chk("t2_cnt", out_cyc.size(), 2);

    // Empty beats
    base = out_cnt;
    src_q.push_back(mk_beat(20, 8'h00, 1'b0));
    run_until_idle("t3a");
    chk("t3a_cnt", out_cnt - base, 0);
    base = out_cnt;
    src_q.push_back(mk_beat(30, 8'h00, 1'b1));
    run_until_idle("t3b");
    chk("t3b_cnt", out_cnt - base, 1);

    // Back-to-back full beats, no bubbles
    clr();
    src_q.push_back(mk_beat(1, 8'hFF, 1'b0));
    src_q.push_back(mk_beat(9, 8'hFF, 1'b0));
    src_q.push_back(mk_beat(17, 8'hFF, 1'b1));
    run_until_idle("t4");
    chk("t4_cnt", out_cyc.size(), 12);
    if (out_cyc.size() >= 12) chk("t4_span", out_cyc[11] - out_cyc[0], 11);

    // Non-contiguous keep: lower empty chunks still emitted
    base = out_cnt;
    src_q.push_back(mk_beat(40, 8'h30, 1'b1));
    run_until_idle("t5");
    chk("t5_cnt", out_cnt - base, 3);

    // Random 64-beat frame at 20% valid / 20% ready
    s_prob = 20;
    m_prob = 20;
    for (int i = 0; i < 64; i++) begin
      for (int w = 0; w < SW; w++) b.dat[w*W +: W] = $urandom;
      n = ($urandom_range(3) == 0) ? int'($urandom_range(SW)) : SW;
      b.keep = '0;
      for (int w = 0; w < n; w++) b.keep[w] = 1'b1;
      b.last = (i == 63);
      src_q.push_back(b);
    end
    run_until_idle("t6");
`ifdef AXIS_OUT_PACKER_STATS_EN
    chk("t6_frames", frame_count, frame_ref);
    chk("t6_stalls", stall_count, stall_ref);
`endif

    // Reset while chunk 2 of a full beat is presented
    s_prob = 100;
    m_prob = 100;
    base = out_cnt;
    src_q.push_back(mk_beat(100, 8'hFF, 1'b1));
    n = 0;
    while (out_cnt - base < 2 && n < 50) begin
      step();
      n++;
    end
    chk("t7_reach", out_cnt - base, 2);
`ifdef AXIS_OUT_PACKER_STATS_EN
    chk("t7_frames_pre", frame_count, frame_ref);
`endif
    do_reset();
    base = out_cnt;
    src_q.push_back(mk_beat(200, 8'h0F, 1'b1));
    run_until_idle("t7");
    chk("t7_cnt", out_cnt - base, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
